mini16sc_loader: RTL and testbench

//  Boot/program loader upstream of the mini16sc CPU core. Takes a byte stream (e.g. from a UART RX),

---
 rtl/mini16sc_loader.sv | 209 ++++++++++++++++++++
 tb/tb_mini16sc_loader.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mini16sc_loader.sv
// Boot loader for mini16sc: decodes byte-stream load frames into I/D memory word writes
// and drives the CPU soft_reset. Optional trailing checksum byte: `define LOADER_CHECKSUM_EN.
module mini16sc_loader #(
    parameter int unsigned WIDTH_I = 16,
    parameter int unsigned WIDTH_D = 16,
    parameter int unsigned DEPTH_I = 8,
    parameter int unsigned DEPTH_D = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [7:0]         in_data,
    input  logic               in_valid,
    output logic               in_ready,
    output logic [DEPTH_I-1:0] mem_i_w_addr,
    output logic [WIDTH_I-1:0] mem_i_w_data,
    output logic               mem_i_we,
    output logic [DEPTH_D-1:0] mem_d_w_addr,
    output logic [WIDTH_D-1:0] mem_d_w_data,
    output logic               mem_d_we,
    output logic               soft_reset,
    output logic               busy,
    output logic               error
);

    localparam logic [7:0] CMD_LOAD_I = 8'hA5;
    localparam logic [7:0] CMD_LOAD_D = 8'h5A;
    localparam logic [7:0] CMD_RUN    = 8'hC3;

    typedef enum logic [3:0] {
        ST_IDLE, ST_ADDR_L, ST_ADDR_H, ST_CNT_L, ST_CNT_H,
        ST_DATA_L, ST_DATA_H, ST_WRITE, ST_SUM, ST_END
    } state_e;

    state_e             state_q, state_d;
    logic [15:0]        addr_q, addr_d;
    logic [15:0]        cnt_q, cnt_d;
    logic [15:0]        idx_q, idx_d;
    logic [7:0]         lo_q, lo_d;
    logic               tgt_d_q, tgt_d_d;
    logic               error_q, error_d;
    logic               soft_reset_q, soft_reset_d;
    logic               busy_q, busy_d;
    logic               in_ready_q, in_ready_d;
    logic               mem_i_we_q, mem_i_we_d;
    logic               mem_d_we_q, mem_d_we_d;
    logic [DEPTH_I-1:0] mem_i_w_addr_q, mem_i_w_addr_d;
    logic [WIDTH_I-1:0] mem_i_w_data_q, mem_i_w_data_d;
    logic [DEPTH_D-1:0] mem_d_w_addr_q, mem_d_w_addr_d;
    logic [WIDTH_D-1:0] mem_d_w_data_q, mem_d_w_data_d;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]         sum_q, sum_d;
`endif

    logic               accept;
    logic [15:0]        word_addr;
    logic [16:0]        idx_next;
    state_e             after_data;

    // Frame decoder: byte states advance on accepted bytes, WRITE/END are single-cycle.
    always_comb begin
        state_d        = state_q;
        addr_d         = addr_q;
        cnt_d          = cnt_q;
        idx_d          = idx_q;
        lo_d           = lo_q;
        tgt_d_d        = tgt_d_q;
        error_d        = error_q;
        soft_reset_d   = soft_reset_q;
        mem_i_we_d     = 1'b0;
        mem_d_we_d     = 1'b0;
        mem_i_w_addr_d = mem_i_w_addr_q;
        mem_i_w_data_d = mem_i_w_data_q;
        mem_d_w_addr_d = mem_d_w_addr_q;
        mem_d_w_data_d = mem_d_w_data_q;
        accept         = in_valid && in_ready_q;
        word_addr      = addr_q + idx_q;
        idx_next       = 17'(idx_q) + 17'd1;
`ifdef LOADER_CHECKSUM_EN
        after_data     = ST_SUM;
        sum_d          = accept ? sum_q + in_data : sum_q;
`else
        after_data     = ST_END;
`endif

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (in_data == CMD_LOAD_I || in_data == CMD_LOAD_D) begin
                        state_d      = ST_ADDR_L;
                        tgt_d_d      = (in_data == CMD_LOAD_D);
                        soft_reset_d = 1'b1;
                        error_d      = 1'b0;
                        idx_d        = 16'd0;
`ifdef LOADER_CHECKSUM_EN
                        sum_d        = in_data;
`endif
                    end else if (in_data == CMD_RUN && !error_q) begin
                        soft_reset_d = 1'b0;
                    end
                end
            end
            ST_ADDR_L: if (accept) begin
                addr_d[7:0] = in_data;
                state_d     = ST_ADDR_H;
            end
            ST_ADDR_H: if (accept) begin
                addr_d[15:8] = in_data;
                state_d      = ST_CNT_L;
            end
            ST_CNT_L: if (accept) begin
                cnt_d[7:0] = in_data;
                state_d    = ST_CNT_H;
            end
            ST_CNT_H: if (accept) begin
                cnt_d[15:8] = in_data;
                state_d     = ({in_data, cnt_q[7:0]} == 16'd0) ? after_data : ST_DATA_L;
            end
            ST_DATA_L: if (accept) begin
                lo_d    = in_data;
                state_d = ST_DATA_H;
            end
            ST_DATA_H: if (accept) begin
                state_d = ST_WRITE;
                if (tgt_d_q) begin
                    mem_d_we_d     = 1'b1;
                    mem_d_w_addr_d = DEPTH_D'(word_addr);
                    mem_d_w_data_d = WIDTH_D'({in_data, lo_q});
                end else begin
                    mem_i_we_d     = 1'b1;
                    mem_i_w_addr_d = DEPTH_I'(word_addr);
                    mem_i_w_data_d = WIDTH_I'({in_data, lo_q});
                end
            end
            ST_WRITE: begin
                idx_d   = idx_next[15:0];
                state_d = (idx_next < 17'(cnt_q)) ? ST_DATA_L : after_data;
            end
`ifdef LOADER_CHECKSUM_EN
            ST_SUM: if (accept) begin
                if (8'(sum_q + in_data) != 8'h00) begin
                    error_d = 1'b1;
                end
                state_d = ST_END;
            end
`endif
            ST_END:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        busy_d     = (state_d != ST_IDLE);
        in_ready_d = !(state_d == ST_WRITE || state_d == ST_END);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q        <= ST_IDLE;
            addr_q         <= 16'd0;
            cnt_q          <= 16'd0;
            idx_q          <= 16'd0;
            lo_q           <= 8'd0;
            tgt_d_q        <= 1'b0;
            error_q        <= 1'b0;
            soft_reset_q   <= 1'b1;
            busy_q         <= 1'b0;
            in_ready_q     <= 1'b1;
            mem_i_we_q     <= 1'b0;
            mem_d_we_q     <= 1'b0;
            mem_i_w_addr_q <= '0;
            mem_i_w_data_q <= '0;
            mem_d_w_addr_q <= '0;
            mem_d_w_data_q <= '0;
`ifdef LOADER_CHECKSUM_EN
            sum_q          <= 8'd0;
`endif
        end else begin
            state_q        <= state_d;
            addr_q         <= addr_d;
            cnt_q          <= cnt_d;
            idx_q          <= idx_d;
            lo_q           <= lo_d;
            tgt_d_q        <= tgt_d_d;
            error_q        <= error_d;
            soft_reset_q   <= soft_reset_d;
            busy_q         <= busy_d;
            in_ready_q     <= in_ready_d;
            mem_i_we_q     <= mem_i_we_d;
            mem_d_we_q     <= mem_d_we_d;
            mem_i_w_addr_q <= mem_i_w_addr_d;
            mem_i_w_data_q <= mem_i_w_data_d;
            mem_d_w_addr_q <= mem_d_w_addr_d;
            mem_d_w_data_q <= mem_d_w_data_d;
`ifdef LOADER_CHECKSUM_EN
            sum_q          <= sum_d;
`endif
        end
    end

    assign in_ready     = in_ready_q;
    assign mem_i_w_addr = mem_i_w_addr_q;
    assign mem_i_w_data = mem_i_w_data_q;
    assign mem_i_we     = mem_i_we_q;
    assign mem_d_w_addr = mem_d_w_addr_q;
    assign mem_d_w_data = mem_d_w_data_q;
    assign mem_d_we     = mem_d_we_q;
    assign soft_reset   = soft_reset_q;
    assign busy         = busy_q;
    assign error        = error_q;

endmodule

// File: tb/tb_mini16sc_loader.sv
// Bench for mini16sc_loader: frame-level model of expected writes / soft_reset / error,
// a per-cycle write monitor, directed literal cases and randomized frames.
module tb_mini16sc_loader;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  mem_i_w_addr;
    logic [15:0] mem_i_w_data;
    logic        mem_i_we;
    logic [7:0]  mem_d_w_addr;
    logic [15:0] mem_d_w_data;
    logic        mem_d_we;
    logic        soft_reset;
    logic        busy;
    logic        error;

    always #5 clk = ~clk;

    mini16sc_loader dut (
        .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .mem_i_w_addr(mem_i_w_addr), .mem_i_w_data(mem_i_w_data), .mem_i_we(mem_i_we),
        .mem_d_w_addr(mem_d_w_addr), .mem_d_w_data(mem_d_w_data), .mem_d_we(mem_d_we),
        .soft_reset(soft_reset), .busy(busy), .error(error)
    );

    typedef struct {
        bit          is_d;
        logic [7:0]  addr;
        logic [15:0] data;
    } wr_t;

    wr_t exp_q[$];
    int  n_tests  = 0;
    int  n_fail   = 0;
    int  i_pulses = 0;
    int  d_pulses = 0;
    bit  mon_en   = 1'b0;
    bit  exp_soft = 1'b1;
    bit  exp_err  = 1'b0;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endfunction

    // Every write pulse must match the next expected word from the model.
    always @(negedge clk) begin
        if (mon_en && reset) begin
            if (!busy) check("idle_in_ready", 32'(in_ready), 32'd1);
            if (mem_i_we && mem_d_we) check("we_exclusive", 32'd1, 32'd0);
            if (mem_i_we || mem_d_we) begin
                if (mem_i_we) i_pulses++; else d_pulses++;
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_write: i_we=%0d d_we=%0d, expected no write", mem_i_we, mem_d_we);
                end else begin
                    wr_t e;
                    e = exp_q.pop_front();
                    check("wr_target_d", 32'(mem_d_we), 32'(e.is_d));
                    check("wr_addr", 32'(e.is_d ? mem_d_w_addr : mem_i_w_addr), 32'(e.addr));
                    check("wr_data", 32'(e.is_d ? mem_d_w_data : mem_i_w_data), 32'(e.data));
                end
            end
        end
    end

    task automatic do_reset();
        @(negedge clk);
        reset    = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        reset    = 1'b1;
        exp_q.delete();
        exp_soft = 1'b1;
        exp_err  = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n;
        n = 0;
        repeat ($urandom_range(0, 2)) begin
            in_data = 8'($urandom);
            @(negedge clk);
        end
        in_data  = b;
        in_valid = 1'b1;
        while (!in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) check("in_ready_timeout", 32'(in_ready), 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("busy_timeout", 32'(busy), 32'd0);
    endtask

    // Model a whole load frame, stream it, then check end-of-frame state.
    task automatic send_frame(input logic [7:0] cmd, input logic [15:0] addr,
                              input logic [15:0] words[$], input bit bad_sum);
        logic [7:0] b[$];
        logic [7:0] s;
        b = {cmd, addr[7:0], addr[15:8], 8'(words.size()), 8'(words.size() >> 8)};
        for (int k = 0; k < words.size(); k++) begin
            b.push_back(words[k][7:0]);
            b.push_back(words[k][15:8]);
            exp_q.push_back('{cmd == 8'h5A, 8'(32'(addr) + k), words[k]});
        end
        exp_soft = 1'b1;
        exp_err  = 1'b0;
`ifdef LOADER_CHECKSUM_EN
        s = 8'd0;
        foreach (b[k]) s = s + b[k];
        b.push_back(8'(8'd0 - s) ^ (bad_sum ? 8'h01 : 8'h00));
        exp_err = bad_sum;
`else
        s = {7'd0, bad_sum};
`endif
        foreach (b[k]) send_byte(b[k]);
        wait_idle();
        check("frame_drained", 32'(exp_q.size()), 32'd0);
        check("frame_soft_reset", 32'(soft_reset), 32'(exp_soft));
        check("frame_error", 32'(error), 32'(exp_err));
    endtask

    task automatic send_run();
        send_byte(8'hC3);
        exp_soft = exp_err;
        check("run_soft_reset", 32'(soft_reset), 32'(exp_soft));
        check("run_busy", 32'(busy), 32'd0);
    endtask

    initial begin
        logic [15:0] w[$];
        int          pi, pd;
        logic [7:0]  x;
        reset    = 1'b1;
        in_valid = 1'b0;
        in_data  = 8'h00;

        // 1: reset state
        do_reset();
        check("rst_soft_reset", 32'(soft_reset), 32'd1);
        check("rst_i_we", 32'(mem_i_we), 32'd0);
        check("rst_d_we", 32'(mem_d_we), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_error", 32'(error), 32'd0);
        check("rst_i_addr", 32'(mem_i_w_addr), 32'd0);
        mon_en = 1'b1;

        // 2: I-mem load of two words, then RUN
        pi = i_pulses;
        w = {16'h1234, 16'h5678};
        send_frame(8'hA5, 16'h0010, w, 1'b0);
        check("t2_i_pulses", 32'(i_pulses - pi), 32'd2);
        check("t2_last_addr", 32'(mem_i_w_addr), 32'h11);
        check("t2_last_data", 32'(mem_i_w_data), 32'h5678);
        send_run();
        check("t2_soft_released", 32'(soft_reset), 32'd0);

        // 3: D-mem load wrapping past 0xFF
        pi = i_pulses;
        pd = d_pulses;
        w = {16'h1111, 16'h2222};
        send_frame(8'h5A, 16'h00FF, w, 1'b0);
        check("t3_d_pulses", 32'(d_pulses - pd), 32'd2);
        check("t3_i_pulses", 32'(i_pulses - pi), 32'd0);
        check("t3_wrap_addr", 32'(mem_d_w_addr), 32'h00);
        check("t3_wrap_data", 32'(mem_d_w_data), 32'h2222);
        check("t3_i_hold", 32'(mem_i_w_data), 32'h5678);

        // 4: stray bytes then an empty frame
        pi = i_pulses;
        pd = d_pulses;
        send_byte(8'h00);
        check("t4_stray0_busy", 32'(busy), 32'd0);
        send_byte(8'h7E);
        check("t4_stray1_busy", 32'(busy), 32'd0);
        send_byte(8'hA5);
        check("t4_busy_in_frame", 32'(busy), 32'd1);
        check("t4_soft_reset", 32'(soft_reset), 32'd1);
        repeat (4) send_byte(8'h00);
`ifdef LOADER_CHECKSUM_EN
        send_byte(8'h5B);
`endif
        wait_idle();
        check("t4_no_writes", 32'((i_pulses - pi) + (d_pulses - pd)), 32'd0);
        exp_soft = 1'b1;
        exp_err  = 1'b0;

        // 5: reset abandons a partial frame
        pi = i_pulses;
        send_byte(8'hA5);
        send_byte(8'h20);
        send_byte(8'h00);
        do_reset();
        check("t5_busy_after_rst", 32'(busy), 32'd0);
        pd = d_pulses;
        w = {16'hABCD};
        send_frame(8'h5A, 16'h0001, w, 1'b0);
        check("t5_no_i_write", 32'(i_pulses - pi), 32'd0);
        check("t5_d_pulses", 32'(d_pulses - pd), 32'd1);
        check("t5_d_addr", 32'(mem_d_w_addr), 32'h01);
        check("t5_d_data", 32'(mem_d_w_data), 32'hABCD);

`ifdef LOADER_CHECKSUM_EN
        // 6: checksum good, bad, then cleared by a new load
        w = {16'h0001};
        send_frame(8'h5A, 16'h0000, w, 1'b0);
        check("t6_good_error", 32'(error), 32'd0);
        send_run();
        check("t6_good_run", 32'(soft_reset), 32'd0);
        send_frame(8'h5A, 16'h0000, w, 1'b1);
        check("t6_bad_error", 32'(error), 32'd1);
        send_run();
        check("t6_bad_run_ignored", 32'(soft_reset), 32'd1);
        w = {16'h0BAD};
        send_frame(8'hA5, 16'h0030, w, 1'b0);
        check("t6_error_cleared", 32'(error), 32'd0);
`endif

        // Randomized frames, stray bytes and RUN commands
        for (int f = 0; f < 40; f++) begin
            case ($urandom_range(0, 5))
                0: begin
                    x = 8'($urandom);
                    if (x == 8'hA5 || x == 8'h5A || x == 8'hC3) x = 8'h01;
                    send_byte(x);
                    check("rnd_stray_busy", 32'(busy), 32'd0);
                end
                1: send_run();
                default: begin
                    w.delete();
                    repeat ($urandom_range(0, 5)) w.push_back(16'($urandom));
`ifdef LOADER_CHECKSUM_EN
                    send_frame($urandom_range(0, 1) ? 8'hA5 : 8'h5A, 16'($urandom), w,
                               ($urandom_range(0, 3) == 0));
`else
                    send_frame($urandom_range(0, 1) ? 8'hA5 : 8'h5A, 16'($urandom), w, 1'b0);
`endif
                end
            endcase
        end
        send_run();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
